// File: rtl/comp_add.sv
// Complex floating-point adder: two independent IEEE-754 lane adders (real, imag)
// with a single output register. Subnormals flush to zero, round-to-nearest-even.

module comp_add_lane #(
  parameter int EW = 8,
  parameter int FW = 23
) (
  input  logic [EW+FW:0] x,
  input  logic [EW+FW:0] y,
  output logic [EW+FW:0] z
);
  localparam int MW  = FW + 4;  // hidden bit + fraction + guard/round/sticky
  localparam int LZW = $clog2(MW);
  localparam logic [EW-1:0]  EMAX = '1;
  localparam logic [EW-1:0]  MWE  = EW'(MW);
  localparam logic [EW+1:0]  E1   = (EW+2)'(1);
  localparam logic [EW+FW:0] QNAN = {1'b0, EMAX, 1'b1, {(FW-1){1'b0}}};

  logic          sx, sy;
  logic [EW-1:0] ex, ey;
  logic [FW-1:0] fx, fy;
  assign {sx, ex, fx} = x;
  assign {sy, ey, fy} = y;

  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
  assign x_nan  = (ex == EMAX) && (fx != '0);
  assign y_nan  = (ey == EMAX) && (fy != '0);
  assign x_inf  = (ex == EMAX) && (fx == '0);
  assign y_inf  = (ey == EMAX) && (fy == '0);
  assign x_zero = (ex == '0);
  assign y_zero = (ey == '0);

  logic           swap, sl, canc, rnd;
  logic [EW-1:0]  el, es, dexp;
  logic [MW-1:0]  ml, ms, msh, mask, mdif, mn;
  logic [MW:0]    msum;
  logic [LZW-1:0] lz;
  logic [EW+1:0]  e;
  logic [FW+1:0]  mr;
  logic [FW-1:0]  frac;
  logic [EW+FW:0] z_fin;

  // Finite, nonzero operands only; specials are selected around this below.
  always_comb begin
    swap = {ey, fy} > {ex, fx};
    sl   = swap ? sy : sx;
    el   = swap ? ey : ex;
    es   = swap ? ex : ey;
    ml   = {1'b1, swap ? fy : fx, 3'b000};
    ms   = {1'b1, swap ? fx : fy, 3'b000};
    dexp = el - es;
    mask = ~({MW{1'b1}} << dexp);
    if (dexp >= MWE) msh = {{(MW-1){1'b0}}, 1'b1};
    else             msh = (ms >> dexp) | {{(MW-1){1'b0}}, |(ms & mask)};
    e    = {2'b00, el};
    msum = {1'b0, ml} + {1'b0, msh};
    mdif = ml - msh;
    lz   = '0;
    for (int i = 0; i < MW; i++)
      if (mdif[i]) lz = LZW'(MW - 1 - i);
    canc = 1'b0;
    if (sx == sy) begin
      if (msum[MW]) begin
        mn = msum[MW:1] | {{(MW-1){1'b0}}, msum[0]};
        e  = e + E1;
      end else begin
        mn = msum[MW-1:0];
      end
    end else begin
      canc = (mdif == '0);
      mn   = mdif << lz;
      e    = e - {{(EW+2-LZW){1'b0}}, lz};
    end
    rnd  = mn[2] & (mn[3] | mn[1] | mn[0]);
    mr   = {1'b0, mn[MW-1:3]} + {{(FW+1){1'b0}}, rnd};
    frac = mr[FW+1] ? mr[FW:1] : mr[FW-1:0];
    if (mr[FW+1]) e = e + E1;
    // e's top bit flags an exponent driven negative by normalisation
    if (canc || e[EW+1] || (e == '0))     z_fin = '0;
    else if (e[EW:0] >= {1'b0, EMAX})     z_fin = {sl, EMAX, {FW{1'b0}}};
    else                                  z_fin = {sl, e[EW-1:0], frac};
  end

  always_comb begin
    z = z_fin;
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) z = QNAN;
    else if (x_inf)                                       z = x;
    else if (y_inf)                                       z = y;
    else if (x_zero && y_zero)                            z = {sx & sy, {(EW+FW){1'b0}}};
    else if (x_zero)                                      z = y;
    else if (y_zero)                                      z = x;
  end
endmodule

module comp_add #(
  parameter  int double = 0,
  localparam int EW = (double != 0) ? 11 : 8,
  localparam int FW = (double != 0) ? 52 : 23,
  localparam int W  = 1 + EW + FW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  output logic [2*W-1:0] result
);
  // Index 1 = real half, index 0 = imaginary half.
  logic [1:0][W-1:0] a_l, b_l, lane_z, sum_d, sum_q;
  assign a_l = a;
  assign b_l = b;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    comp_add_lane #(.EW(EW), .FW(FW)) u_lane (
      .x(a_l[g]),
      .y(b_l[g]),
      .z(lane_z[g])
    );
  end

  always_comb sum_d = lane_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sum_q <= '0;
    else     sum_q <= sum_d;
  end

  assign result = sum_q;
endmodule

// File: tb/tb_comp_add.sv
// Bench for comp_add (binary32 lanes): directed vectors with literal expectations
// plus an exact big-integer model checked against the output every cycle.

module tb_comp_add;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [63:0] result;
  logic [63:0] ref_q;
  logic        chk_en = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  comp_add #(.double(0)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .result(result));

  always #5 clk = ~clk;

  // Exact sum on a common scale, then one round-to-nearest-even to 24 bits.
  function automatic logic [31:0] f32_add(input logic [31:0] x, input logic [31:0] y);
    logic [7:0]   ex, ey;
    logic [319:0] mx, my, mag, rem, half, q;
    logic         s;
    int           emin, p, sh, e;
    ex = x[30:23];
    ey = y[30:23];
    if ((ex == 8'hFF && x[22:0] != 0) || (ey == 8'hFF && y[22:0] != 0)) return 32'h7FC00000;
    if (ex == 8'hFF && ey == 8'hFF) return (x[31] == y[31]) ? x : 32'h7FC00000;
    if (ex == 8'hFF) return x;
    if (ey == 8'hFF) return y;
    if (ex == 0 && ey == 0) return {x[31] & y[31], 31'b0};
    if (ex == 0) return y;
    if (ey == 0) return x;
    emin = (ex < ey) ? int'(ex) : int'(ey);
    mx = {296'b0, 1'b1, x[22:0]} << (int'(ex) - emin);
    my = {296'b0, 1'b1, y[22:0]} << (int'(ey) - emin);
    if (x[31] == y[31]) begin mag = mx + my; s = x[31]; end
    else if (mx > my)   begin mag = mx - my; s = x[31]; end
    else if (my > mx)   begin mag = my - mx; s = y[31]; end
    else return 32'h0;
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    e = p + emin - 23;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((320'd1 << sh) - 320'd1);
      half = 320'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 320'd1;
      if (q[24]) begin q = q >> 1; e++; end
    end else begin
      q = mag << (23 - p);
    end
    if (e <= 0)   return 32'h0;
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [63:0] c_add(input logic [63:0] x, input logic [63:0] y);
    return {f32_add(x[63:32], y[63:32]), f32_add(x[31:0], y[31:0])};
  endfunction

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Expected output one edge after the inputs, zero while in reset.
  always @(posedge clk or posedge rst)
    if (rst) ref_q <= '0;
    else     ref_q <= c_add(a, b);

  always @(negedge clk)
    if (chk_en) check("model", result, ref_q);

  task automatic vec(input string nm, input logic [63:0] va, input logic [63:0] vb,
                     input logic [63:0] exp);
    @(negedge clk);
    a = va;
    b = vb;
    check({nm, "_model"}, c_add(va, vb), exp);
    @(posedge clk);
    #1 check(nm, result, exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check("reset_async", result, 64'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_hold", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    vec("tenth",       64'h3DCCCCCD3DCCCCCD, 64'h3DCCCCCD3DCCCCCD, 64'h3E4CCCCD3E4CCCCD);
    vec("cancel",      64'h3F8000003FC00000, 64'hBF8000003E800000, 64'h000000003FE00000);
    vec("carry",       64'h4040000040000000, 64'h3F8000003F800000, 64'h4080000040400000);
    vec("tie_up",      64'h3F8000003F800001, 64'h3380000033800000, 64'h3F8000003F800002);
    vec("tie_even",    64'h3F8000003F800003, 64'h3380000033800000, 64'h3F8000003F800004);
    vec("ovf_inf",     64'h7F7FFFFF7F800000, 64'h7F7FFFFFFF800000, 64'h7F8000007FC00000);
    vec("nan_lanes",   64'h7FA000003F800000, 64'h3F8000007FA00000, 64'h7FC000007FC00000);
    vec("subnorm",     64'h0000000180000000, 64'h0000000080000000, 64'h0000000080000000);
    vec("zero_signs",  64'h8000000080000000, 64'h0000000080000000, 64'h0000000080000000);
    vec("inf_finite",  64'hFF8000007F800000, 64'h3F800000C0000000, 64'hFF8000007F800000);
    vec("far_shift",   64'h3F80000040000000, 64'hB0800000BFC00000, 64'h3F8000003F000000);
    vec("underflow",   64'h008000013F800000, 64'h808000003F800000, 64'h0000000040000000);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 2 == 0) b[62:55] = a[62:55] ^ 8'($urandom_range(0, 3));
      if (i % 3 == 0) b[30:23] = a[30:23] ^ 8'($urandom_range(0, 15));
    end

    @(negedge clk);
    a = 64'h3F8000003F800000;
    b = 64'h3F8000003F800000;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_mid", result, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    vec("post_reset",  64'h3F80000040400000, 64'h4000000040400000, 64'h4040000040C00000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
